// File: rtl/cfu_mac_arbiter.sv
// cfu_mac_arbiter
//   Shares one single-outstanding CFU datapath between two requesters (m0, m1).
//   Round-robin arbitration with one transaction in flight. A requester that
//   issues a MAC (funct3 == 3) locks the arbiter so the shared accumulator is
//   not disturbed, until it sends a non-MAC command or sits idle for
//   LOCK_TIMEOUT cycles (0 disables the timeout).
//
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   mN_cmd_*  (N = 0,1)       : requester command channel (valid/ready)
//   mN_rsp_*                  : requester response channel (valid/ready)
//   s_cmd_*                   : command channel towards the CFU
//   s_rsp_*                   : response channel from the CFU
//   lock_active, lock_owner   : MAC lock status
//   busy                      : high whenever a transaction is in progress
module cfu_mac_arbiter #(
  parameter int LOCK_TIMEOUT = 64,
  parameter int TIMER_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_cmd_valid,
  output logic        m0_cmd_ready,
  input  logic [9:0]  m0_cmd_payload_function_id,
  input  logic [31:0] m0_cmd_payload_inputs_0,
  input  logic [31:0] m0_cmd_payload_inputs_1,
  output logic        m0_rsp_valid,
  input  logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_payload_outputs_0,
  input  logic        m1_cmd_valid,
  output logic        m1_cmd_ready,
  input  logic [9:0]  m1_cmd_payload_function_id,
  input  logic [31:0] m1_cmd_payload_inputs_0,
  input  logic [31:0] m1_cmd_payload_inputs_1,
  output logic        m1_rsp_valid,
  input  logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_payload_outputs_0,
  output logic        s_cmd_valid,
  input  logic        s_cmd_ready,
  output logic [9:0]  s_cmd_payload_function_id,
  output logic [31:0] s_cmd_payload_inputs_0,
  output logic [31:0] s_cmd_payload_inputs_1,
  input  logic        s_rsp_valid,
  output logic        s_rsp_ready,
  input  logic [31:0] s_rsp_payload_outputs_0,
  output logic        lock_active,
  output logic        lock_owner,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DELIVER} state_t;

  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(LOCK_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

  state_t             state_q, state_d;
  logic [9:0]         id_q, id_d;
  logic [31:0]        in0_q, in0_d;
  logic [31:0]        in1_q, in1_d;
  logic [31:0]        result_q, result_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic               lock_active_q, lock_active_d;
  logic               lock_owner_q, lock_owner_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic        req0, req1, any_req, sel, accept, owner_valid;
  logic [9:0]  sel_id;
  logic [31:0] sel_in0, sel_in1;

  // Arbitration: while locked only the owner is eligible. On a tie the
  // requester that did not win last time gets the grant. cmd_ready is masked
  // during reset so no requester sees a handshake that the reset discards.
  always_comb begin
    req0        = m0_cmd_valid && (!lock_active_q || !lock_owner_q);
    req1        = m1_cmd_valid && (!lock_active_q ||  lock_owner_q);
    any_req     = req0 || req1;
    sel         = (req0 && req1) ? ~last_grant_q : req1;
    accept      = (state_q == ST_IDLE) && any_req && !reset;
    sel_id      = sel ? m1_cmd_payload_function_id : m0_cmd_payload_function_id;
    sel_in0     = sel ? m1_cmd_payload_inputs_0 : m0_cmd_payload_inputs_0;
    sel_in1     = sel ? m1_cmd_payload_inputs_1 : m0_cmd_payload_inputs_1;
    owner_valid = lock_owner_q ? m1_cmd_valid : m0_cmd_valid;
  end

  // Next-state logic for the transaction FSM, the holding registers and the
  // MAC lock. The lock is only updated in IDLE: at a handshake, or by the
  // idle timer when the owner has nothing to send.
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    in0_d         = in0_q;
    in1_d         = in1_q;
    result_d      = result_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    timer_d       = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d         = sel_id;
          in0_d        = sel_in0;
          in1_d        = sel_in1;
          grant_d      = sel;
          last_grant_d = sel;
          timer_d      = TIMEOUT_LOAD;
          state_d      = ST_ISSUE;
          // Clear-MACs (upper id bits set) also take the lock: they start a
          // new accumulation sequence.
          if (sel_id[2:0] == 3'd3) begin
            lock_active_d = 1'b1;
            lock_owner_d  = sel;
          end else if (lock_active_q) begin
            lock_active_d = 1'b0;
          end
        end else if ((LOCK_TIMEOUT != 0) && lock_active_q && !owner_valid) begin
          if (timer_q <= TIMER_ONE) begin
            lock_active_d = 1'b0;
            timer_d       = '0;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end
      end
      ST_ISSUE: begin
        if (s_cmd_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (s_rsp_valid) begin
          result_d = s_rsp_payload_outputs_0;
          state_d  = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (grant_q ? m1_rsp_ready : m0_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register. last_grant resets to 1 so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      id_q          <= '0;
      in0_q         <= '0;
      in1_q         <= '0;
      result_q      <= '0;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      in0_q         <= in0_d;
      in1_q         <= in1_d;
      result_q      <= result_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      timer_q       <= timer_d;
    end
  end

  // The result register feeds both ports; only rsp_valid is steered.
  assign m0_cmd_ready              = accept && !sel;
  assign m1_cmd_ready              = accept &&  sel;
  assign s_cmd_valid               = (state_q == ST_ISSUE);
  assign s_cmd_payload_function_id = id_q;
  assign s_cmd_payload_inputs_0    = in0_q;
  assign s_cmd_payload_inputs_1    = in1_q;
  assign s_rsp_ready               = (state_q == ST_WAIT);
  assign m0_rsp_valid              = (state_q == ST_DELIVER) && !grant_q;
  assign m1_rsp_valid              = (state_q == ST_DELIVER) &&  grant_q;
  assign m0_rsp_payload_outputs_0  = result_q;
  assign m1_rsp_payload_outputs_0  = result_q;
  assign lock_active               = lock_active_q;
  assign lock_owner                = lock_owner_q;
  assign busy                      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cfu_mac_arbiter.sv
// tb_cfu_mac_arbiter
//   Drives two requesters and a behavioural CFU stub around cfu_mac_arbiter.
//   A reference model tracks the arbitration/lock rules cycle by cycle and
//   pushes expected results into per-port queues; a monitor pops and compares
//   them whenever a response handshake happens.
module tb_cfu_mac_arbiter;

  localparam int LOCK_TO = 4;

  typedef struct packed {
    logic [9:0]  id;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_cmd_valid, m0_cmd_ready, m0_rsp_valid, m0_rsp_ready;
  logic [9:0]  m0_cmd_payload_function_id;
  logic [31:0] m0_cmd_payload_inputs_0, m0_cmd_payload_inputs_1, m0_rsp_payload_outputs_0;
  logic        m1_cmd_valid, m1_cmd_ready, m1_rsp_valid, m1_rsp_ready;
  logic [9:0]  m1_cmd_payload_function_id;
  logic [31:0] m1_cmd_payload_inputs_0, m1_cmd_payload_inputs_1, m1_rsp_payload_outputs_0;
  logic        s_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_ready;
  logic [9:0]  s_cmd_payload_function_id;
  logic [31:0] s_cmd_payload_inputs_0, s_cmd_payload_inputs_1, s_rsp_payload_outputs_0;
  logic        lock_active, lock_owner, busy;

  cfu_mac_arbiter #(.LOCK_TIMEOUT(LOCK_TO), .TIMER_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready),
    .m0_cmd_payload_function_id(m0_cmd_payload_function_id),
    .m0_cmd_payload_inputs_0(m0_cmd_payload_inputs_0),
    .m0_cmd_payload_inputs_1(m0_cmd_payload_inputs_1),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
    .m0_rsp_payload_outputs_0(m0_rsp_payload_outputs_0),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready),
    .m1_cmd_payload_function_id(m1_cmd_payload_function_id),
    .m1_cmd_payload_inputs_0(m1_cmd_payload_inputs_0),
    .m1_cmd_payload_inputs_1(m1_cmd_payload_inputs_1),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
    .m1_rsp_payload_outputs_0(m1_rsp_payload_outputs_0),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_payload_function_id(s_cmd_payload_function_id),
    .s_cmd_payload_inputs_0(s_cmd_payload_inputs_0),
    .s_cmd_payload_inputs_1(s_cmd_payload_inputs_1),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
    .s_rsp_payload_outputs_0(s_rsp_payload_outputs_0),
    .lock_active(lock_active), .lock_owner(lock_owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus control shared between the main sequence and the driver process.
  cmd_t cq0[$], cq1[$];
  bit   en0 = 0, en1 = 0, rand_valid = 0, rand_rsp_ready = 0, rand_sready = 0, cfu_hold = 0;
  int   cmd_stall = 0, rsp_stall0 = 0, rsp_stall1 = 0;

  // Scoreboard and logs written by the monitor.
  logic [31:0] exp0[$], exp1[$], rsp0_log[$], rsp1_log[$];
  int          grant_log[$], hs_log[$], rsp_cyc_log[$];
  int          cyc = 0, last_lat = 0;

  // CFU semantics: add, sub, mul, MAC (upper id bits set clears the
  // accumulator first); other funct3 values just xor the operands.
  function automatic logic [31:0] golden(input logic [9:0] id, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] acc_in,
                                         output logic [31:0] acc_out);
    logic [31:0] prod;
    prod    = a * b;
    acc_out = acc_in;
    case (id[2:0])
      3'd0: golden = a + b;
      3'd1: golden = a - b;
      3'd2: golden = prod;
      3'd3: begin
        acc_out = ((id[9:3] != 7'd0) ? 32'd0 : acc_in) + prod;
        golden  = acc_out;
      end
      default: golden = a ^ b;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic applyStimulus(input int port, input logic [9:0] id,
                               input logic [31:0] a, input logic [31:0] b);
    cmd_t c;
    c.id = id; c.a = a; c.b = b;
    if (port == 0) cq0.push_back(c); else cq1.push_back(c);
  endtask

  // Requester drivers and CFU stub. Handshakes are sampled on the falling
  // edge and the consequences applied just after the next rising edge.
  bit          a_hs0, a_hs1, a_cf, a_rf, a_sv, a_rv0, a_rv1, a_rst;
  logic [9:0]  a_id;
  logic [31:0] a_in0, a_in1, cfu_acc, nacc;
  initial begin
    m0_cmd_valid = 0; m0_cmd_payload_function_id = 0; m0_cmd_payload_inputs_0 = 0;
    m0_cmd_payload_inputs_1 = 0; m0_rsp_ready = 0;
    m1_cmd_valid = 0; m1_cmd_payload_function_id = 0; m1_cmd_payload_inputs_0 = 0;
    m1_cmd_payload_inputs_1 = 0; m1_rsp_ready = 0;
    s_cmd_ready = 0; s_rsp_valid = 0; s_rsp_payload_outputs_0 = 0; cfu_acc = 0;
    forever begin
      @(negedge clk);
      a_hs0 = m0_cmd_valid && m0_cmd_ready;
      a_hs1 = m1_cmd_valid && m1_cmd_ready;
      a_cf  = s_cmd_valid && s_cmd_ready;
      a_rf  = s_rsp_valid && s_rsp_ready;
      a_sv  = s_cmd_valid;
      a_rv0 = m0_rsp_valid;
      a_rv1 = m1_rsp_valid;
      a_rst = reset;
      a_id  = s_cmd_payload_function_id;
      a_in0 = s_cmd_payload_inputs_0;
      a_in1 = s_cmd_payload_inputs_1;
      @(posedge clk);
      #1;
      if (a_hs0 && cq0.size() > 0) void'(cq0.pop_front());
      if (a_hs1 && cq1.size() > 0) void'(cq1.pop_front());
      if (a_rst) begin
        s_rsp_valid = 0;
        cfu_acc     = 0;
      end else begin
        if (a_rf) s_rsp_valid = 0;
        if (a_cf) begin
          s_rsp_payload_outputs_0 = golden(a_id, a_in0, a_in1, cfu_acc, nacc);
          cfu_acc = nacc;
          if (!cfu_hold) s_rsp_valid = 1;
        end
      end
      if (a_sv && cmd_stall > 0) cmd_stall--;
      if (a_rv0 && rsp_stall0 > 0) rsp_stall0--;
      if (a_rv1 && rsp_stall1 > 0) rsp_stall1--;
      s_cmd_ready  = rand_sready ? (($urandom % 2) == 0) : (cmd_stall == 0);
      m0_rsp_ready = (rsp_stall0 == 0) && (!rand_rsp_ready || (($urandom % 2) == 0));
      m1_rsp_ready = (rsp_stall1 == 0) && (!rand_rsp_ready || (($urandom % 2) == 0));
      if (en0 && cq0.size() > 0 && (!rand_valid || (($urandom % 4) != 0))) begin
        m0_cmd_valid = 1;
        m0_cmd_payload_function_id = cq0[0].id;
        m0_cmd_payload_inputs_0 = cq0[0].a;
        m0_cmd_payload_inputs_1 = cq0[0].b;
      end else begin
        m0_cmd_valid = 0;
      end
      if (en1 && cq1.size() > 0 && (!rand_valid || (($urandom % 4) != 0))) begin
        m1_cmd_valid = 1;
        m1_cmd_payload_function_id = cq1[0].id;
        m1_cmd_payload_inputs_0 = cq1[0].a;
        m1_cmd_payload_inputs_1 = cq1[0].b;
      end else begin
        m1_cmd_valid = 0;
      end
    end
  end

  // Reference model and monitor. The model thinks in terms of "a transaction
  // is outstanding or not", a lock owner and a count of idle cycles since the
  // owner's last command; it predicts who may be accepted each cycle and what
  // each response must contain.
  bit          m_out = 0, m_lock = 0, m_owner = 0, m_last = 1, m_grant = 0, m_lat_seen = 1;
  bit          was_out, q0, q1, g, e_r0, e_r1, own_v;
  int          m_idle = 0, m_hs_cyc = 0;
  logic [31:0] m_acc = 0, m_nacc, m_res;
  cmd_t        m_hold, m_new;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      m_out = 0; m_lock = 0; m_owner = 0; m_last = 1; m_idle = 0; m_acc = 0;
      m_lat_seen = 1;
      exp0.delete();
      exp1.delete();
    end else begin
      was_out = m_out;
      q0 = m0_cmd_valid && (!m_lock || !m_owner);
      q1 = m1_cmd_valid && (!m_lock ||  m_owner);
      g  = (q0 && q1) ? !m_last : q1;
      e_r0 = !was_out && (q0 || q1) && !g;
      e_r1 = !was_out && (q0 || q1) &&  g;
      checkBit("m0_cmd_ready", m0_cmd_ready, e_r0);
      checkBit("m1_cmd_ready", m1_cmd_ready, e_r1);
      checkBit("busy", busy, was_out);
      checkBit("lock_active", lock_active, m_lock);
      if (m_lock) checkBit("lock_owner", lock_owner, m_owner);
      if (!was_out) checkBit("s_cmd_valid_when_free", s_cmd_valid, 1'b0);
      if (s_cmd_valid) begin
        checkOutput("s_cmd_id", {22'd0, s_cmd_payload_function_id}, {22'd0, m_hold.id});
        checkOutput("s_cmd_in0", s_cmd_payload_inputs_0, m_hold.a);
        checkOutput("s_cmd_in1", s_cmd_payload_inputs_1, m_hold.b);
      end
      checkBit("m0_rsp_valid_routing", m0_rsp_valid && !(was_out && !m_grant), 1'b0);
      checkBit("m1_rsp_valid_routing", m1_rsp_valid && !(was_out &&  m_grant), 1'b0);
      if (m0_cmd_valid && m0_cmd_ready) begin grant_log.push_back(0); hs_log.push_back(cyc); end
      if (m1_cmd_valid && m1_cmd_ready) begin grant_log.push_back(1); hs_log.push_back(cyc); end
      if (was_out && !m_lat_seen && (m_grant ? m1_rsp_valid : m0_rsp_valid)) begin
        last_lat   = cyc - m_hs_cyc;
        m_lat_seen = 1;
      end
      if (was_out) begin
        if (!m_grant && m0_rsp_valid && m0_rsp_ready) begin
          if (exp0.size() == 0) checkOutput("m0_unexpected_rsp", m0_rsp_payload_outputs_0, 32'hDEAD_BEEF);
          else checkOutput("m0_result", m0_rsp_payload_outputs_0, exp0.pop_front());
          rsp0_log.push_back(m0_rsp_payload_outputs_0);
          rsp_cyc_log.push_back(cyc);
          m_out = 0;
        end
        if (m_grant && m1_rsp_valid && m1_rsp_ready) begin
          if (exp1.size() == 0) checkOutput("m1_unexpected_rsp", m1_rsp_payload_outputs_0, 32'hDEAD_BEEF);
          else checkOutput("m1_result", m1_rsp_payload_outputs_0, exp1.pop_front());
          rsp1_log.push_back(m1_rsp_payload_outputs_0);
          rsp_cyc_log.push_back(cyc);
          m_out = 0;
        end
      end else if (q0 || q1) begin
        m_new.id = g ? m1_cmd_payload_function_id : m0_cmd_payload_function_id;
        m_new.a  = g ? m1_cmd_payload_inputs_0 : m0_cmd_payload_inputs_0;
        m_new.b  = g ? m1_cmd_payload_inputs_1 : m0_cmd_payload_inputs_1;
        m_res = golden(m_new.id, m_new.a, m_new.b, m_acc, m_nacc);
        m_acc = m_nacc;
        if (g) exp1.push_back(m_res); else exp0.push_back(m_res);
        m_hold = m_new; m_grant = g; m_last = g; m_out = 1;
        m_hs_cyc = cyc; m_lat_seen = 0;
        if (m_new.id[2:0] == 3'd3) begin
          m_lock = 1; m_owner = g; m_idle = 0;
        end else begin
          m_lock = 0;
        end
      end else begin
        own_v = m_owner ? m1_cmd_valid : m0_cmd_valid;
        if (LOCK_TO != 0 && m_lock && !own_v) begin
          m_idle++;
          if (m_idle >= LOCK_TO) begin
            m_lock = 0; m_idle = 0;
          end
        end
      end
    end
  end

  task automatic clear_logs();
    grant_log.delete(); hs_log.delete(); rsp_cyc_log.delete();
    rsp0_log.delete(); rsp1_log.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1;
    en0 = 0; en1 = 0; rand_valid = 0; rand_rsp_ready = 0; rand_sready = 0; cfu_hold = 0;
    cmd_stall = 0; rsp_stall0 = 0; rsp_stall1 = 0;
    cq0.delete(); cq1.delete();
    @(posedge clk);
    #2;
    reset = 0;
    clear_logs();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((cq0.size() != 0 || cq1.size() != 0 || m_out || exp0.size() != 0 ||
            exp1.size() != 0) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: still busy after %0d cycles, required to drain", name, budget);
    end
  endtask

  task automatic check_grants(input string name, input int exp_q[$]);
    checkOutput({name, "_count"}, grant_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++)
      checkOutput($sformatf("%s_%0d", name, i), grant_log[i], exp_q[i]);
  endtask

  task automatic check_results(input string name, input logic [31:0] got[$],
                               input logic [31:0] exp_q[$]);
    checkOutput({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      checkOutput($sformatf("%s_%0d", name, i), got[i], exp_q[i]);
  endtask

  initial begin
    do_reset();

    $display("[TB] single ADD");
    applyStimulus(0, 10'd0, 32'd5, 32'd7);
    en0 = 1;
    wait_idle("add_drain", 100);
    checkOutput("add_latency", last_lat, 32'd3);
    check_results("add_m0", rsp0_log, '{32'd12});
    checkOutput("add_m1_count", rsp1_log.size(), 32'd0);

    $display("[TB] round robin");
    do_reset();
    applyStimulus(0, 10'd2, 32'd3, 32'd4);
    applyStimulus(0, 10'd2, 32'd3, 32'd4);
    applyStimulus(1, 10'd2, 32'd6, 32'd7);
    applyStimulus(1, 10'd2, 32'd6, 32'd7);
    en0 = 1; en1 = 1;
    wait_idle("rr_drain", 200);
    check_grants("rr_grant", '{0, 1, 0, 1});
    check_results("rr_m0", rsp0_log, '{32'd12, 32'd12});
    check_results("rr_m1", rsp1_log, '{32'd42, 32'd42});

    $display("[TB] MAC lock");
    do_reset();
    applyStimulus(1, 10'd11, 32'd2, 32'd3);
    applyStimulus(1, 10'd3, 32'd4, 32'd5);
    applyStimulus(1, 10'd0, 32'd1, 32'd1);
    applyStimulus(0, 10'd0, 32'd10, 32'd20);
    en1 = 1;
    for (int i = 0; i < 50 && grant_log.size() == 0; i++) begin
      @(posedge clk);
      #2;
    end
    en0 = 1;
    wait_idle("lock_drain", 200);
    check_grants("lock_grant", '{1, 1, 1, 0});
    check_results("lock_m1", rsp1_log, '{32'd6, 32'd26, 32'd2});
    check_results("lock_m0", rsp0_log, '{32'd30});

    $display("[TB] lock timeout");
    do_reset();
    applyStimulus(0, 10'd3, 32'd1, 32'd1);
    applyStimulus(1, 10'd0, 32'd2, 32'd2);
    en0 = 1; en1 = 1;
    wait_idle("timeout_drain", 200);
    check_grants("timeout_grant", '{0, 1});
    if (hs_log.size() == 2 && rsp_cyc_log.size() >= 1)
      checkOutput("timeout_gap", hs_log[1] - rsp_cyc_log[0], LOCK_TO + 1);
    else
      checkOutput("timeout_log_size", hs_log.size(), 32'd2);

    $display("[TB] backpressure");
    do_reset();
    cmd_stall = 3; rsp_stall0 = 5;
    applyStimulus(0, 10'd1, 32'd100, 32'd30);
    applyStimulus(0, 10'd0, 32'd1, 32'd2);
    en0 = 1;
    wait_idle("bp_drain", 200);
    check_results("bp_m0", rsp0_log, '{32'd70, 32'd3});
    if (hs_log.size() >= 1 && rsp_cyc_log.size() >= 1)
      checkOutput("bp_duration", rsp_cyc_log[0] - hs_log[0], 32'd11);
    else
      checkOutput("bp_log_size", hs_log.size(), 32'd2);

    $display("[TB] reset during WAIT with lock held");
    do_reset();
    cfu_hold = 1;
    applyStimulus(0, 10'd3, 32'd2, 32'd2);
    en0 = 1;
    for (int i = 0; i < 50 && !(s_rsp_ready && lock_active); i++) begin
      @(posedge clk);
      #2;
    end
    checkBit("pre_reset_wait_locked", s_rsp_ready && lock_active, 1'b1);
    reset = 1; en0 = 0; cfu_hold = 0;
    cq0.delete(); cq1.delete();
    @(posedge clk);
    #2;
    reset = 0;
    clear_logs();
    checkBit("rst_m0_cmd_ready", m0_cmd_ready, 1'b0);
    checkBit("rst_m1_cmd_ready", m1_cmd_ready, 1'b0);
    checkBit("rst_m0_rsp_valid", m0_rsp_valid, 1'b0);
    checkBit("rst_m1_rsp_valid", m1_rsp_valid, 1'b0);
    checkBit("rst_s_cmd_valid", s_cmd_valid, 1'b0);
    checkBit("rst_s_rsp_ready", s_rsp_ready, 1'b0);
    checkBit("rst_lock_active", lock_active, 1'b0);
    checkBit("rst_lock_owner", lock_owner, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkOutput("rst_s_cmd_id", {22'd0, s_cmd_payload_function_id}, 32'd0);
    checkOutput("rst_s_cmd_in0", s_cmd_payload_inputs_0, 32'd0);
    checkOutput("rst_s_cmd_in1", s_cmd_payload_inputs_1, 32'd0);
    checkOutput("rst_rsp_payload", m0_rsp_payload_outputs_0, 32'd0);
    applyStimulus(0, 10'd0, 32'd1, 32'd1);
    applyStimulus(1, 10'd0, 32'd2, 32'd2);
    en0 = 1; en1 = 1;
    wait_idle("post_rst_drain", 200);
    check_grants("post_rst_grant", '{0, 1});

    $display("[TB] randomized traffic");
    do_reset();
    rand_valid = 1; rand_rsp_ready = 1; rand_sready = 1;
    for (int i = 0; i < 25; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic [9:0] rid;
        rid = {(($urandom % 4) == 0) ? 7'($urandom) : 7'd0, 3'($urandom % 4)};
        applyStimulus(p, rid, 32'($urandom % 1000), 32'($urandom % 1000));
      end
    end
    en0 = 1; en1 = 1;
    wait_idle("random_drain", 10000);
    checkOutput("random_m0_count", rsp0_log.size(), 32'd25);
    checkOutput("random_m1_count", rsp1_log.size(), 32'd25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cfu_mac_arbiter.md
Name: cfu_mac_arbiter

Overview:
- Shares one single-outstanding CFU datapath (add/sub/mul/MAC, funct3 = function_id[2:0]) between two requester ports, m0 and m1.
- Requesters use the same cmd/rsp valid-ready protocol as the CFU.
- Round-robin arbitration, one transaction in flight at a time.
- MAC lock: the CFU accumulator is shared state, so a requester running a MAC sequence keeps the grant until the sequence ends or a timeout expires.

Parameters:
LOCK_TIMEOUT, 64, idle cycles in IDLE (owner cmd_valid low) before a MAC lock is dropped; 0 = never time out
TIMER_W, 8, width of the lock timer; must satisfy LOCK_TIMEOUT < 2**TIMER_W

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
mN_cmd_valid  in  1  requester N command valid (N = 0,1; each m* line below exists per requester)
mN_cmd_ready  out  1  requester N command accepted
mN_cmd_payload_function_id  in  10  requester N function id
mN_cmd_payload_inputs_0  in  32  requester N operand 0
mN_cmd_payload_inputs_1  in  32  requester N operand 1
mN_rsp_valid  out  1  requester N response valid
mN_rsp_ready  in  1  requester N response taken
mN_rsp_payload_outputs_0  out  32  requester N result
s_cmd_valid  out  1  command to CFU
s_cmd_ready  in  1  CFU accepts command
s_cmd_payload_function_id  out  10  forwarded function id
s_cmd_payload_inputs_0  out  32  forwarded operand 0
s_cmd_payload_inputs_1  out  32  forwarded operand 1
s_rsp_valid  in  1  CFU response valid
s_rsp_ready  out  1  arbiter takes CFU response
s_rsp_payload_outputs_0  in  32  CFU result
lock_active  out  1  MAC lock held
lock_owner  out  1  requester holding the lock (valid when lock_active)
busy  out  1  state != IDLE

Behaviour:
- One clock, clk. Reset is synchronous, active-high; all state updates on the posedge of clk.
- Reset:
  - state = IDLE.
  - All valid/ready outputs 0; all payload registers 0.
  - lock_active = 0, lock_owner = 0, last_grant = 1 (so m0 wins the first tie), timer = 0.
  - Reset mid-transaction abandons it silently; the CFU shares the same reset.
- FSM, four states:
  - IDLE:
    - Eligible requesters: if lock_active, only lock_owner; otherwise both.
    - Selection: if both eligible requesters have cmd_valid high, grant goes to ~last_grant; otherwise to the single valid one.
    - mG_cmd_ready = 1 combinationally, for the granted requester only, in IDLE only.
    - On handshake: latch id and operands into holding registers, set grant = G, last_grant = G, go to ISSUE.
  - ISSUE:
    - s_cmd_valid = 1 with the held payload.
    - On s_cmd_ready, go to WAIT.
    - Held payload stays stable while waiting for s_cmd_ready.
  - WAIT:
    - s_rsp_ready = 1.
    - On s_rsp_valid, capture s_rsp_payload_outputs_0 into the result register and go to DELIVER.
    - A CFU response outside WAIT is not taken; the CFU holds it.
  - DELIVER:
    - mG_rsp_valid = 1 with the result; the other requester's rsp_valid stays 0.
    - On mG_rsp_ready, go to IDLE. The next command may be accepted the following cycle.
- Latency:
  - Command handshake at cycle T.
  - s_cmd_valid at T+1.
  - With a one-cycle CFU, s_rsp_valid at T+2.
  - mG_rsp_valid at T+3.
  - With rsp_ready held high, the next accept is at T+4, i.e. 4-cycle throughput.
- Payloads: mN_rsp_payload_outputs_0 carries the result register for both ports; only rsp_valid is steered. Payloads are passed bit-exact, with no arithmetic in the arbiter.
- MAC lock, evaluated at command handshake:
  - funct3 == 3 accepted from G: lock_active = 1, lock_owner = G, timer = LOCK_TIMEOUT. This includes clear-MACs (id[9:3] != 0).
  - funct3 != 3 accepted from the owner: lock_active = 0 at handshake; that command still executes normally.
  - Non-owners are never eligible while locked, so no other lock transition exists.
- Lock timer (only when LOCK_TIMEOUT != 0):
  - Decrements each cycle that state == IDLE, lock_active = 1 and owner cmd_valid = 0.
  - Reloads to LOCK_TIMEOUT on each owner handshake.
  - When it reaches 0: lock_active = 0 on that edge, and the next cycle arbitrates both requesters.
- Simultaneous events:
  - Timer expiry and owner cmd_valid rising in the same cycle: the owner's handshake wins, the lock stays held and the timer reloads.
  - Both requesters valid while locked: only the owner is served; the other waits with cmd_ready = 0.
- Requesters must hold cmd_valid and payload until cmd_ready. Dropping cmd_valid before the handshake withdraws the request harmlessly.

Test Plan:
- Single ADD: m0 sends id=0, inputs 5 and 7; s_rsp returns 12 one cycle later -> m0_rsp_valid at T+3 with 12; m1_rsp_valid stays 0.
- Round robin: m0 and m1 both continuously valid with MUL (id=2), unlocked -> grants alternate m0, m1, m0, m1; results 3*4=12 and 6*7=42 routed to the correct port.
- MAC lock: m1 sends id=8+3 (clear, 2*3), then id=3 (4*5), with m0 valid throughout -> m0 is blocked and m1 receives 6 then 26. m1 then sends id=0 -> lock drops at that handshake and m0 is granted next.
- Timeout: LOCK_TIMEOUT=4; m0 issues MAC then idles while m1 is valid -> m1_cmd_ready is 0 for 4 idle cycles; lock_active falls and m1 is granted on the following cycle.
- Backpressure: s_cmd_ready held 0 for 3 cycles, then m0_rsp_ready held 0 for 5 cycles -> payloads stable, no second accept, busy=1 throughout, correct result delivered.
- Reset mid-WAIT: assert reset with lock_active=1 -> next cycle all outputs 0, lock cleared, busy=0, last_grant=1; a subsequent simultaneous request grants m0.
